// File: rtl/qcldpc_info_loader.sv
// Ping-pong information-block loader for a QC-LDPC encoder.
// Two banks each buffer one codeword (NUM_INFO_BLKS blocks of MAX_Z bits)
// together with the one-hot Z tag it was written with. One bank fills from
// the upstream side while the other drains to the encoder.
//
// bank state | meaning
// EMPTY      | free, next accept starts a codeword and latches the Z tag
// FILLING    | partially written codeword
// FULL       | complete codeword, nothing handed to the encoder yet
// DRAINING   | complete codeword, at least one block handed to the encoder
module qcldpc_info_loader #(
  parameter int NUM_Z                = 3,
  parameter int MAX_Z                = 81,
  parameter int NUM_INFO_BLKS        = 20,
  parameter int Z_VALUES [NUM_Z]     = '{27, 54, 81}
) (
  input  logic                             CLK,
  input  logic                             rst_n,
  input  logic [NUM_Z-1:0]                 req_z,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [MAX_Z-1:0]                 data_in,
  output logic                             enc_valid,
  input  logic                             enc_ready,
  output logic [MAX_Z-1:0]                 enc_blk,
  output logic [$clog2(NUM_INFO_BLKS)-1:0] enc_blk_idx,
  output logic                             enc_first,
  output logic                             enc_last,
  output logic [NUM_Z-1:0]                 enc_z_sel,
  output logic                             err_z
);

  localparam int CNT_W = $clog2(NUM_INFO_BLKS);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_e;

  bank_state_e      state_q [2];
  bank_state_e      state_d [2];
  logic [NUM_Z-1:0] tag_q   [2];
  logic [NUM_Z-1:0] tag_d   [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic             err_z_q, err_z_d;
  logic [MAX_Z-1:0] mem_q [2][NUM_INFO_BLKS];

  logic             wr_acc, rd_hs;
  logic             wr_first, wr_last, rd_last;
  logic             z_onehot;
  logic [NUM_Z-1:0] new_tag, wr_tag;
  logic [MAX_Z-1:0] wr_data;

  // Valid-bit mask for a one-hot Z tag: ones in [Z-1:0], zeros above.
  function automatic logic [MAX_Z-1:0] z_mask(input logic [NUM_Z-1:0] tag);
    logic [MAX_Z-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_Z; i++) begin
      if (tag[i]) m = m | ({MAX_Z{1'b1}} >> (MAX_Z - Z_VALUES[i]));
    end
    return m;
  endfunction

  assign in_ready  = (state_q[wr_ptr_q] == EMPTY) || (state_q[wr_ptr_q] == FILLING);
  assign enc_valid = (state_q[rd_ptr_q] == FULL)  || (state_q[rd_ptr_q] == DRAINING);
  assign wr_acc    = in_valid && in_ready;
  assign rd_hs     = enc_valid && enc_ready;

  assign wr_first  = (state_q[wr_ptr_q] == EMPTY);
  assign wr_last   = (wr_cnt_q == CNT_W'(NUM_INFO_BLKS - 1));
  assign rd_last   = (rd_cnt_q == CNT_W'(NUM_INFO_BLKS - 1));

  // An illegal Z select falls back to the widest lifting size so no data bits are lost.
  assign z_onehot  = $onehot(req_z);
  assign new_tag   = z_onehot ? req_z : (NUM_Z'(1) << (NUM_Z - 1));
  assign wr_tag    = wr_first ? new_tag : tag_q[wr_ptr_q];
  assign wr_data   = data_in & z_mask(wr_tag);

  // Outputs come only from stored state; idle outputs are forced to zero.
  assign enc_blk     = enc_valid ? mem_q[rd_ptr_q][rd_cnt_q] : '0;
  assign enc_blk_idx = rd_cnt_q;
  assign enc_first   = enc_valid && (rd_cnt_q == '0);
  assign enc_last    = enc_valid && rd_last;
  assign enc_z_sel   = enc_valid ? tag_q[rd_ptr_q] : '0;
  assign err_z       = err_z_q;

  // Next-state for bank states, tags, pointers and counters; fill and drain are independent.
  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    err_z_d  = 1'b0;

    if (wr_acc) begin
      if (wr_first) begin
        tag_d[wr_ptr_q] = new_tag;
        err_z_d         = !z_onehot;
      end
      if (wr_last) begin
        state_d[wr_ptr_q] = FULL;
        wr_cnt_d          = '0;
        wr_ptr_d          = ~wr_ptr_q;
      end else begin
        state_d[wr_ptr_q] = FILLING;
        wr_cnt_d          = wr_cnt_q + 1'b1;
      end
    end

    if (rd_hs) begin
      if (rd_last) begin
        state_d[rd_ptr_q] = EMPTY;
        rd_cnt_d          = '0;
        rd_ptr_d          = ~rd_ptr_q;
      end else begin
        state_d[rd_ptr_q] = DRAINING;
        rd_cnt_d          = rd_cnt_q + 1'b1;
      end
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= EMPTY;
        tag_q[b]   <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      err_z_q  <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= state_d[b];
        tag_q[b]   <= tag_d[b];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      err_z_q  <= err_z_d;
    end
  end

  // Block storage; contents are don't-care after reset since bank states gate visibility.
  always_ff @(posedge CLK) begin
    if (wr_acc) mem_q[wr_ptr_q][wr_cnt_q] <= wr_data;
  end

endmodule

// File: tb/tb_qcldpc_info_loader.sv
// Directed bench for qcldpc_info_loader with hand-derived expected blocks.
module tb_qcldpc_info_loader;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic [2:0]  req_z;
  logic        in_valid;
  logic        in_ready;
  logic [80:0] data_in;
  logic        enc_valid;
  logic        enc_ready;
  logic [80:0] enc_blk;
  logic [4:0]  enc_blk_idx;
  logic        enc_first;
  logic        enc_last;
  logic [2:0]  enc_z_sel;
  logic        err_z;

  int total  = 0;
  int passed = 0;

  qcldpc_info_loader dut (
    .CLK(CLK), .rst_n(rst_n), .req_z(req_z), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .enc_valid(enc_valid), .enc_ready(enc_ready), .enc_blk(enc_blk),
    .enc_blk_idx(enc_blk_idx), .enc_first(enc_first), .enc_last(enc_last),
    .enc_z_sel(enc_z_sel), .err_z(err_z)
  );

  always #5 CLK = ~CLK;

  // Block pattern with ones spread over all three 27-bit slices.
  function automatic logic [80:0] gen(input int cw, input int i);
    return {27'(32'h5A5A5A5 ^ cw), 27'(32'h3C3C3C3 + i), 27'(cw * 100 + i + 1)};
  endfunction

  function automatic logic [80:0] expd(input int cw, input int i, input logic [2:0] zsel);
    logic [80:0] m;
    int z;
    z = zsel[0] ? 27 : (zsel[1] ? 54 : 81);
    m = '0;
    for (int b = 0; b < 81; b++) if (b < z) m[b] = 1'b1;
    return gen(cw, i) & m;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Offer blocks first..first+n-1 of codeword cw, waiting (bounded) for in_ready.
  task automatic drive_blocks(input int cw, input int first, input int n, input logic [2:0] z);
    for (int i = first; i < first + n; i++) begin
      int t;
      t = 0;
      in_valid = 1'b1;
      data_in  = gen(cw, i);
      req_z    = z;
      while (!in_ready && t < 500) begin
        step();
        t++;
      end
      if (t >= 500) begin
        total++;
        $display("FAIL fill_timeout cw=%0d blk=%0d in_ready stayed 0, required 1", cw, i);
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", in_ready); else passed++;
    total++; if (enc_valid !== 1'b0) $display("FAIL rst_enc_valid got %b want 0", enc_valid); else passed++;
    total++; if (enc_blk !== 81'd0) $display("FAIL rst_enc_blk got %h want 0", enc_blk); else passed++;
    total++; if (enc_blk_idx !== 5'd0) $display("FAIL rst_idx got %0d want 0", enc_blk_idx); else passed++;
    total++; if ({enc_first, enc_last} !== 2'b00) $display("FAIL rst_first_last got %b want 00", {enc_first, enc_last}); else passed++;
    total++; if (enc_z_sel !== 3'b000) $display("FAIL rst_z_sel got %b want 000", enc_z_sel); else passed++;
    total++; if (err_z !== 1'b0) $display("FAIL rst_err_z got %b want 0", err_z); else passed++;
  endtask

  task automatic test_basic();
    enc_ready = 1'b1;
    drive_blocks(1, 0, 19, 3'b001);
    total++; if (enc_valid !== 1'b0) $display("FAIL basic_early_valid got %b want 0", enc_valid); else passed++;
    drive_blocks(1, 19, 1, 3'b001);
    total++; if (enc_valid !== 1'b1) $display("FAIL basic_latency enc_valid got %b want 1", enc_valid); else passed++;
    for (int k = 0; k < 20; k++) begin
      total++; if (enc_valid !== 1'b1) $display("FAIL basic_valid k=%0d got %b want 1", k, enc_valid); else passed++;
      total++; if (enc_blk_idx !== 5'(k)) $display("FAIL basic_idx got %0d want %0d", enc_blk_idx, k); else passed++;
      total++; if (enc_blk !== expd(1, k, 3'b001)) $display("FAIL basic_blk k=%0d got %h want %h", k, enc_blk, expd(1, k, 3'b001)); else passed++;
      total++; if (enc_z_sel !== 3'b001) $display("FAIL basic_z_sel got %b want 001", enc_z_sel); else passed++;
      total++; if (enc_first !== (k == 0)) $display("FAIL basic_first k=%0d got %b", k, enc_first); else passed++;
      total++; if (enc_last !== (k == 19)) $display("FAIL basic_last k=%0d got %b", k, enc_last); else passed++;
      step();
    end
    total++; if (enc_valid !== 1'b0) $display("FAIL basic_done enc_valid got %b want 0", enc_valid); else passed++;
  endtask

  task automatic test_err_z();
    enc_ready = 1'b1;
    drive_blocks(2, 0, 1, 3'b011);
    total++; if (err_z !== 1'b1) $display("FAIL errz_pulse got %b want 1", err_z); else passed++;
    step();
    total++; if (err_z !== 1'b0) $display("FAIL errz_one_cycle got %b want 0", err_z); else passed++;
    drive_blocks(2, 1, 19, 3'b011);
    total++; if (err_z !== 1'b0) $display("FAIL errz_no_repeat got %b want 0", err_z); else passed++;
    for (int k = 0; k < 20; k++) begin
      total++; if (enc_z_sel !== 3'b100) $display("FAIL errz_z_sel got %b want 100", enc_z_sel); else passed++;
      total++; if (enc_blk !== gen(2, k)) $display("FAIL errz_blk k=%0d got %h want %h", k, enc_blk, gen(2, k)); else passed++;
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] zs [3];
    zs[0] = 3'b001; zs[1] = 3'b010; zs[2] = 3'b100;
    enc_ready = 1'b0;
    drive_blocks(30, 0, 20, zs[0]);
    drive_blocks(31, 0, 20, zs[1]);
    in_valid = 1'b1;
    data_in  = gen(32, 0);
    req_z    = zs[2];
    for (int c = 0; c < 3; c++) begin
      step();
      total++; if (in_ready !== 1'b0) $display("FAIL b2b_full_in_ready got %b want 0", in_ready); else passed++;
      total++; if (enc_blk !== expd(30, 0, zs[0])) $display("FAIL b2b_hold_blk got %h want %h", enc_blk, expd(30, 0, zs[0])); else passed++;
    end
    fork
      drive_blocks(32, 0, 20, zs[2]);
      begin
        enc_ready = 1'b1;
        for (int n = 0; n < 60; n++) begin
          int t;
          t = 0;
          while (!enc_valid && t < 100) begin
            step();
            t++;
          end
          total++;
          if (t >= 100) $display("FAIL b2b_timeout n=%0d enc_valid stayed 0", n);
          else if (enc_blk !== expd(30 + n / 20, n % 20, zs[n / 20]) || enc_blk_idx !== 5'(n % 20)
                   || enc_z_sel !== zs[n / 20])
            $display("FAIL b2b_out n=%0d got blk=%h idx=%0d z=%b want blk=%h idx=%0d z=%b", n, enc_blk,
                     enc_blk_idx, enc_z_sel, expd(30 + n / 20, n % 20, zs[n / 20]), n % 20, zs[n / 20]);
          else passed++;
          step();
        end
      end
    join
    total++; if (enc_valid !== 1'b0) $display("FAIL b2b_done enc_valid got %b want 0", enc_valid); else passed++;
  endtask

  task automatic test_stall();
    int k;
    int cyc;
    enc_ready = 1'b0;
    drive_blocks(10, 0, 20, 3'b010);
    k = 0;
    cyc = 0;
    while (k < 20 && cyc < 400) begin
      enc_ready = 1'($urandom_range(0, 1));
      total++;
      if (enc_valid !== 1'b1 || enc_blk_idx !== 5'(k) || enc_blk !== expd(10, k, 3'b010))
        $display("FAIL stall_out cyc=%0d got v=%b idx=%0d blk=%h want v=1 idx=%0d blk=%h", cyc, enc_valid,
                 enc_blk_idx, enc_blk, k, expd(10, k, 3'b010));
      else passed++;
      if (enc_ready) k++;
      step();
      cyc++;
    end
    enc_ready = 1'b1;
    total++; if (k !== 20) $display("FAIL stall_count got %0d want 20", k); else passed++;
    total++; if (enc_valid !== 1'b0) $display("FAIL stall_done enc_valid got %b want 0", enc_valid); else passed++;
  endtask

  task automatic test_stream();
    logic [2:0] zs [3];
    zs[0] = 3'b100; zs[1] = 3'b001; zs[2] = 3'b010;
    enc_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          in_valid = 1'b1;
          data_in  = gen(20 + i / 20, i % 20);
          req_z    = zs[i / 20];
          total++; if (in_ready !== 1'b1) $display("FAIL stream_in_ready i=%0d got %b want 1", i, in_ready); else passed++;
          step();
        end
        in_valid = 1'b0;
      end
      begin
        int t;
        t = 0;
        while (!enc_valid && t < 40) begin
          step();
          t++;
        end
        total++; if (t !== 20) $display("FAIL stream_first_out got cycle %0d want 20", t); else passed++;
        for (int n = 0; n < 60; n++) begin
          total++;
          if (enc_valid !== 1'b1 || enc_blk !== expd(20 + n / 20, n % 20, zs[n / 20]) || enc_blk_idx !== 5'(n % 20))
            $display("FAIL stream_out n=%0d got v=%b idx=%0d blk=%h want v=1 idx=%0d blk=%h", n, enc_valid,
                     enc_blk_idx, enc_blk, n % 20, expd(20 + n / 20, n % 20, zs[n / 20]));
          else passed++;
          step();
        end
      end
    join
  endtask

  task automatic test_reset_mid();
    enc_ready = 1'b0;
    drive_blocks(50, 0, 20, 3'b001);
    drive_blocks(51, 0, 7, 3'b010);
    enc_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    total++; if (enc_blk_idx !== 5'd5) $display("FAIL rmid_idx got %0d want 5", enc_blk_idx); else passed++;
    #2 rst_n = 1'b0;
    #1;
    test_reset();
    enc_ready = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    total++; if (enc_valid !== 1'b0) $display("FAIL rmid_no_stale got %b want 0", enc_valid); else passed++;
    drive_blocks(52, 0, 20, 3'b100);
    total++; if (enc_valid !== 1'b1) $display("FAIL rmid_valid got %b want 1", enc_valid); else passed++;
    total++; if (enc_blk_idx !== 5'd0 || enc_first !== 1'b1) $display("FAIL rmid_idx0 got idx=%0d first=%b want 0/1", enc_blk_idx, enc_first); else passed++;
    total++; if (enc_z_sel !== 3'b100) $display("FAIL rmid_z_sel got %b want 100", enc_z_sel); else passed++;
    total++; if (enc_blk !== gen(52, 0)) $display("FAIL rmid_blk got %h want %h", enc_blk, gen(52, 0)); else passed++;
    enc_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    total++; if (enc_valid !== 1'b0) $display("FAIL rmid_done enc_valid got %b want 0", enc_valid); else passed++;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_z     = 3'b001;
    in_valid  = 1'b0;
    data_in   = '0;
    enc_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    test_reset();
    test_basic();
    test_err_z();
    test_back_to_back();
    test_stall();
    test_stream();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
